riscv_region_profiler: RTL and testbench

RISCV_REGION_PROFILER -- requirements
Module: riscv_region_profiler

---
 rtl/riscv_region_profiler.sv | 130 +++++++++++++
 tb/tb_riscv_region_profiler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_region_profiler.sv
// riscv_region_profiler: per-region PC-window profiler counting retired instructions and cycles
// between a START_PC and END_PC retirement, with a register read/write port.
module riscv_region_profiler #(
    parameter int NUM_REGIONS = 4,
    parameter int CNT_W       = 32,
    localparam int ADDR_W     = $clog2(NUM_REGIONS) + 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   retire_valid_i,
    input  logic [31:0]            retire_pc_i,
    input  logic                   cfg_we_i,
    input  logic [ADDR_W-1:0]      cfg_addr_i,
    input  logic [31:0]            cfg_data_i,
    input  logic [ADDR_W-1:0]      rd_addr_i,
    output logic [31:0]            rd_data_o,
    output logic [NUM_REGIONS-1:0] done_o,
    output logic                   irq_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    state_t                 st     [NUM_REGIONS];
    state_t                 st_n   [NUM_REGIONS];
    logic [31:0]            start_pc [NUM_REGIONS];
    logic [31:0]            end_pc   [NUM_REGIONS];
    logic [CNT_W-1:0]       ret    [NUM_REGIONS];
    logic [CNT_W-1:0]       ret_n  [NUM_REGIONS];
    logic [CNT_W-1:0]       cyc    [NUM_REGIONS];
    logic [CNT_W-1:0]       cyc_n  [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] en;
    logic [NUM_REGIONS-1:0] irq_en;
    logic [NUM_REGIONS-1:0] ctrl_wr;
    logic [ADDR_W-1:0]      wr_rgn;
    logic [ADDR_W-1:0]      rd_rgn;
    logic [31:0]            rd_n;
    logic [63:0]            ret_x;
    logic [63:0]            cyc_x;

    assign wr_rgn = cfg_addr_i >> 3;
    assign rd_rgn = rd_addr_i >> 3;

    // Clear wins over everything; disabling an ACTIVE window parks it in IDLE with counts held.
    always_comb begin
        ctrl_wr = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            st_n[r]    = st[r];
            ret_n[r]   = ret[r];
            cyc_n[r]   = cyc[r];
            ctrl_wr[r] = cfg_we_i && wr_rgn == ADDR_W'(r) && cfg_addr_i[2:0] == 3'd2;
            if (ctrl_wr[r] && cfg_data_i[1]) begin
                st_n[r]  = IDLE;
                ret_n[r] = '0;
                cyc_n[r] = '0;
            end else if (ctrl_wr[r] && !cfg_data_i[0] && st[r] == ACTIVE) begin
                st_n[r] = IDLE;
            end else if (st[r] == IDLE) begin
                if (en[r] && retire_valid_i && retire_pc_i == start_pc[r]) begin
                    st_n[r]  = ACTIVE;
                    ret_n[r] = CNT_W'(1);
                    cyc_n[r] = CNT_W'(1);
                end
            end else if (st[r] == ACTIVE) begin
                cyc_n[r] = &cyc[r] ? cyc[r] : cyc[r] + CNT_W'(1);
                if (retire_valid_i)
                    ret_n[r] = &ret[r] ? ret[r] : ret[r] + CNT_W'(1);
                if (retire_valid_i && retire_pc_i == end_pc[r])
                    st_n[r] = DONE;
            end
        end
    end

    always_comb begin
        rd_n  = '0;
        ret_x = '0;
        cyc_x = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (rd_rgn == ADDR_W'(r)) begin
                ret_x = 64'(ret[r]);
                cyc_x = 64'(cyc[r]);
                case (rd_addr_i[2:0])
                    3'd0:    rd_n = start_pc[r];
                    3'd1:    rd_n = end_pc[r];
                    3'd2:    rd_n = {26'd0, st[r], 1'b0, irq_en[r], 1'b0, en[r]};
                    3'd3:    rd_n = ret_x[31:0];
                    3'd4:    rd_n = ret_x[63:32];
                    3'd5:    rd_n = cyc_x[31:0];
                    3'd6:    rd_n = cyc_x[63:32];
                    default: rd_n = '0;
                endcase
            end
        end
    end

    always_comb begin
        done_o = '0;
        for (int r = 0; r < NUM_REGIONS; r++)
            done_o[r] = st[r] == DONE;
        irq_o = |(done_o & irq_en);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                st[r]       <= IDLE;
                start_pc[r] <= '0;
                end_pc[r]   <= '0;
                ret[r]      <= '0;
                cyc[r]      <= '0;
            end
            en        <= '0;
            irq_en    <= '0;
            rd_data_o <= '0;
        end else begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                st[r]  <= st_n[r];
                ret[r] <= ret_n[r];
                cyc[r] <= cyc_n[r];
                if (cfg_we_i && wr_rgn == ADDR_W'(r) && cfg_addr_i[2:0] == 3'd0)
                    start_pc[r] <= cfg_data_i;
                if (cfg_we_i && wr_rgn == ADDR_W'(r) && cfg_addr_i[2:0] == 3'd1)
                    end_pc[r] <= cfg_data_i;
                if (ctrl_wr[r]) begin
                    en[r]     <= cfg_data_i[0];
                    irq_en[r] <= cfg_data_i[2];
                end
            end
            rd_data_o <= rd_n;
        end
    end
endmodule

// File: tb/tb_riscv_region_profiler.sv
// tb_riscv_region_profiler: directed scenarios with hand-computed expectations.
module tb_riscv_region_profiler;
    logic        clk = 1'b0;
    logic        rst;
    logic        rv, we;
    logic [31:0] pc, wd, rd;
    logic [4:0]  wa, ra;
    logic [3:0]  done;
    logic        irq;
    logic        b_rv, b_we;
    logic [31:0] b_pc, b_wd, b_rd;
    logic [2:0]  b_wa, b_ra;
    logic [0:0]  b_done;
    logic        b_irq;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    riscv_region_profiler dut (
        .clk_i(clk), .rst_i(rst), .retire_valid_i(rv), .retire_pc_i(pc),
        .cfg_we_i(we), .cfg_addr_i(wa), .cfg_data_i(wd), .rd_addr_i(ra),
        .rd_data_o(rd), .done_o(done), .irq_o(irq)
    );

    riscv_region_profiler #(.NUM_REGIONS(1), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .retire_valid_i(b_rv), .retire_pc_i(b_pc),
        .cfg_we_i(b_we), .cfg_addr_i(b_wa), .cfg_data_i(b_wd), .rd_addr_i(b_ra),
        .rd_data_o(b_rd), .done_o(b_done), .irq_o(b_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [31:0] d);
        ra = a;
        tick();
        d = rd;
    endtask

    task automatic retire(input logic [31:0] p);
        rv = 1'b1; pc = p;
        tick();
        rv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL reset_rd got %h want 0", rd); end
        tests++; if (done !== 4'd0 || irq !== 1'b0) begin fails++; $display("FAIL reset_done got %b/%b want 0000/0", done, irq); end
        tests++; if (b_rd !== 32'd0 || b_done !== 1'b0) begin fails++; $display("FAIL reset_b got %h/%b want 0/0", b_rd, b_done); end
        rst = 1'b0;
        rdreg(5'd2, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL reset_ctrl got %h want 0", v); end
    endtask

    task automatic test_window();
        wr(5'd0, 32'h100);
        wr(5'd1, 32'h140);
        wr(5'd2, 32'h1);
        for (int i = 0; i < 17; i++) retire(32'h100 + 32'(i * 4));
        tests++; if (done !== 4'b0001) begin fails++; $display("FAIL window_done got %b want 0001", done); end
        rdreg(5'd2, v);
        tests++; if (v !== 32'h21) begin fails++; $display("FAIL window_ctrl got %h want 21", v); end
        rdreg(5'd3, v);
        tests++; if (v !== 32'd17) begin fails++; $display("FAIL window_retired got %0d want 17", v); end
        rdreg(5'd5, v);
        tests++; if (v !== 32'd17) begin fails++; $display("FAIL window_cycles got %0d want 17", v); end
        rdreg(5'd4, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL window_ret_hi got %h want 0", v); end
        wr(5'd2, 32'h2);
    endtask

    task automatic test_gaps();
        wr(5'd2, 32'h1);
        for (int i = 0; i < 33; i++) begin
            rv = (i % 2 == 0);
            pc = 32'h100 + 32'((i / 2) * 4);
            tick();
        end
        rv = 1'b0;
        rdreg(5'd3, v);
        tests++; if (v !== 32'd17) begin fails++; $display("FAIL gaps_retired got %0d want 17", v); end
        rdreg(5'd5, v);
        tests++; if (v !== 32'd33) begin fails++; $display("FAIL gaps_cycles got %0d want 33", v); end
        wr(5'd2, 32'h2);
        rdreg(5'd5, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL gaps_clear got %0d want 0", v); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; wa = 5'd0; wd = 32'h500; ra = 5'd0;
        tick();
        we = 1'b0;
        tests++; if (rd !== 32'h100) begin fails++; $display("FAIL rw_same_cycle got %h want 100", rd); end
        rdreg(5'd0, v);
        tests++; if (v !== 32'h500) begin fails++; $display("FAIL rw_after got %h want 500", v); end
    endtask

    task automatic test_same_pc();
        wr(5'd8, 32'h200);
        wr(5'd9, 32'h200);
        wr(5'd10, 32'h5);
        retire(32'h200);
        retire(32'h204);
        tests++; if (done !== 4'b0000) begin fails++; $display("FAIL samepc_early got %b want 0000", done); end
        retire(32'h200);
        tests++; if (done !== 4'b0010 || irq !== 1'b1) begin fails++; $display("FAIL samepc_done got %b/%b want 0010/1", done, irq); end
        rdreg(5'd11, v);
        tests++; if (v !== 32'd3) begin fails++; $display("FAIL samepc_retired got %0d want 3", v); end
        rdreg(5'd10, v);
        tests++; if (v !== 32'h25) begin fails++; $display("FAIL samepc_ctrl got %h want 25", v); end
        wr(5'd10, 32'h2);
        tests++; if (irq !== 1'b0 || done !== 4'd0) begin fails++; $display("FAIL samepc_clr_irq got %b/%b want 0/0000", irq, done); end
        rdreg(5'd11, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL samepc_clr_ret got %0d want 0", v); end
        rdreg(5'd13, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL samepc_clr_cyc got %0d want 0", v); end
    endtask

    task automatic test_clear_start();
        wr(5'd24, 32'h300);
        wr(5'd25, 32'h310);
        wr(5'd26, 32'h1);
        we = 1'b1; wa = 5'd26; wd = 32'h3; rv = 1'b1; pc = 32'h300;
        tick();
        we = 1'b0; rv = 1'b0;
        rdreg(5'd26, v);
        tests++; if (v !== 32'h01) begin fails++; $display("FAIL clrstart_ctrl got %h want 01", v); end
        rdreg(5'd27, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL clrstart_ret got %0d want 0", v); end
        retire(32'h300);
        rdreg(5'd26, v);
        tests++; if (v !== 32'h11) begin fails++; $display("FAIL clrstart_restart got %h want 11", v); end
        rdreg(5'd27, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL clrstart_ret1 got %0d want 1", v); end
        wr(5'd26, 32'h2);
    endtask

    task automatic test_multi();
        wr(5'd0, 32'h600);
        wr(5'd1, 32'h608);
        wr(5'd16, 32'h600);
        wr(5'd17, 32'h604);
        wr(5'd2, 32'h1);
        wr(5'd18, 32'h1);
        retire(32'h600);
        retire(32'h604);
        retire(32'h608);
        tests++; if (done !== 4'b0101) begin fails++; $display("FAIL multi_done got %b want 0101", done); end
        rdreg(5'd3, v);
        tests++; if (v !== 32'd3) begin fails++; $display("FAIL multi_r0 got %0d want 3", v); end
        rdreg(5'd19, v);
        tests++; if (v !== 32'd2) begin fails++; $display("FAIL multi_r2 got %0d want 2", v); end
        wr(5'd2, 32'h2);
        wr(5'd18, 32'h2);
    endtask

    task automatic test_reset_mid();
        wr(5'd16, 32'h400);
        wr(5'd17, 32'h4ff0);
        wr(5'd18, 32'h1);
        for (int i = 0; i < 5; i++) retire(32'h400 + 32'(i * 4));
        rdreg(5'd19, v);
        tests++; if (v !== 32'd5) begin fails++; $display("FAIL midrst_pre got %0d want 5", v); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (rd !== 32'd0 || done !== 4'd0) begin fails++; $display("FAIL midrst_out got %h/%b want 0/0000", rd, done); end
        rdreg(5'd19, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL midrst_ret got %0d want 0", v); end
        rdreg(5'd18, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL midrst_ctrl got %h want 0", v); end
        rdreg(5'd16, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL midrst_start got %h want 0", v); end
    endtask

    task automatic test_saturate();
        b_we = 1'b1; b_wa = 3'd0; b_wd = 32'h1000; tick();
        b_wa = 3'd1; b_wd = 32'h2000; tick();
        b_wa = 3'd2; b_wd = 32'h1; tick();
        b_we = 1'b0;
        b_rv = 1'b1; b_pc = 32'h1000; tick();
        b_rv = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        b_rv = 1'b1; b_pc = 32'h2000; tick();
        b_rv = 1'b0;
        tests++; if (b_done !== 1'b1) begin fails++; $display("FAIL sat_done got %b want 1", b_done); end
        b_ra = 3'd5; tick();
        tests++; if (b_rd !== 32'h0000ffff) begin fails++; $display("FAIL sat_cycles got %h want 0000ffff", b_rd); end
        b_ra = 3'd6; tick();
        tests++; if (b_rd !== 32'd0) begin fails++; $display("FAIL sat_cyc_hi got %h want 0", b_rd); end
        b_ra = 3'd3; tick();
        tests++; if (b_rd !== 32'd2) begin fails++; $display("FAIL sat_retired got %0d want 2", b_rd); end
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; pc = '0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        b_rv = 1'b0; b_pc = '0; b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra = '0;
        test_reset();
        test_window();
        test_gaps();
        test_back_to_back();
        test_same_pc();
        test_clear_start();
        test_multi();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
